// File: rtl/conv2d_mc.sv
// Multi-channel strided 2-D convolution engine with loadable weights and per-filter bias.
// Define CONV2D_MC_RELU_EN to clamp negative results to zero (fused ReLU).
module conv2d_mc #(
    parameter int IN_W        = 28,
    parameter int IN_H        = 28,
    parameter int IN_CH       = 1,
    parameter int K           = 3,
    parameter int NUM_FILTERS = 8,
    parameter int STRIDE      = 1,
    parameter int DATA_W      = 16,
    parameter int FRAC        = 8,
    localparam int OUT_W = (IN_W - K) / STRIDE + 1,
    localparam int OUT_H = (IN_H - K) / STRIDE + 1,
    localparam int N     = IN_CH * K * K,
    localparam int WN    = NUM_FILTERS * N + NUM_FILTERS,
    localparam int WA_W  = $clog2(WN),
    localparam int IA_W  = $clog2(IN_W * IN_H * IN_CH),
    localparam int OA_W  = $clog2(OUT_W * OUT_H * NUM_FILTERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_wr_en,
    input  logic [WA_W-1:0]          w_wr_addr,
    input  logic signed [DATA_W-1:0] w_wr_data,
    output logic                     in_rd,
    output logic [IA_W-1:0]          in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OA_W-1:0]          out_addr,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + $clog2(N) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int OXW   = $clog2(OUT_W + 1);
    localparam int OYW   = $clog2(OUT_H + 1);
    localparam int FW    = $clog2(NUM_FILTERS + 1);
    localparam int KCW   = $clog2(K + 1);
    localparam int CW    = $clog2(IN_CH + 1);
    localparam int NW    = $clog2(N + 1);
    localparam logic signed [SUM_W-1:0] SAT_HI = (SUM_W'(1) <<< (DATA_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_FINAL, S_WRITE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [OXW-1:0]            ox_q, ox_d;
    logic [OYW-1:0]            oy_q, oy_d;
    logic [FW-1:0]             f_q, f_d;
    logic [KCW-1:0]            kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]             c_q, c_d;
    logic [NW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  res_q, res_d;
    logic [OA_W-1:0]           oaddr_q, oaddr_d;

    // Weight store has no reset: contents survive a reset between runs.
    logic signed [DATA_W-1:0]  wmem [2**WA_W];
    logic signed [DATA_W-1:0]  win_q [2**NW];

    logic [WA_W-1:0]           w_idx, b_idx;
    logic signed [DATA_W-1:0]  w_cur, x_cur, b_cur, sat;
    logic signed [PW-1:0]      prod;
    logic signed [SUM_W-1:0]   sum, shifted;
    logic                      xfer_in;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign in_rd     = (state_q == S_FETCH);
    assign out_valid = (state_q == S_WRITE);
    assign out_addr  = oaddr_q;
    assign out_data  = res_q;
    assign xfer_in   = in_rd && in_valid;

    assign in_addr = IA_W'(32'(ox_q) * STRIDE + 32'(kx_q)
                         + (32'(oy_q) * STRIDE + 32'(ky_q)) * IN_W
                         + 32'(c_q) * (IN_W * IN_H));

    assign w_idx   = WA_W'(32'(f_q) * N + 32'(k_q));
    assign b_idx   = WA_W'(NUM_FILTERS * N + 32'(f_q));
    assign w_cur   = wmem[w_idx];
    assign b_cur   = wmem[b_idx];
    assign x_cur   = win_q[k_q];
    assign prod    = PW'(w_cur) * PW'(x_cur);
    assign sum     = SUM_W'(acc_q) + (SUM_W'(b_cur) <<< FRAC);
    assign shifted = sum >>> FRAC;

    always_comb begin
        if (shifted > SAT_HI)
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < SAT_LO)
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat = shifted[DATA_W-1:0];
`ifdef CONV2D_MC_RELU_EN
        if (sat[DATA_W-1])
            sat = '0;
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        f_d     = f_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        res_d   = res_q;
        oaddr_d = oaddr_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                ox_d = '0; oy_d = '0; f_d = '0;
                kx_d = '0; ky_d = '0; c_d = '0; k_d = '0;
                acc_d = '0;
            end
            S_FETCH: if (xfer_in) begin
                if (k_q == NW'(N - 1)) begin
                    k_d = '0; kx_d = '0; ky_d = '0; c_d = '0;
                    f_d = '0; acc_d = '0;
                    state_d = S_MAC;
                end else begin
                    k_d = k_q + NW'(1);
                    if (kx_q == KCW'(K - 1)) begin
                        kx_d = '0;
                        if (ky_q == KCW'(K - 1)) begin
                            ky_d = '0;
                            c_d  = c_q + CW'(1);
                        end else begin
                            ky_d = ky_q + KCW'(1);
                        end
                    end else begin
                        kx_d = kx_q + KCW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == NW'(N - 1)) begin
                    k_d = '0;
                    state_d = S_FINAL;
                end else begin
                    k_d = k_q + NW'(1);
                end
            end
            S_FINAL: begin
                res_d   = sat;
                oaddr_d = OA_W'(32'(ox_q) + 32'(oy_q) * OUT_W + 32'(f_q) * (OUT_W * OUT_H));
                state_d = S_WRITE;
            end
            S_WRITE: if (out_ready) begin
                // Remaining filters reuse the buffered window; otherwise advance the position.
                if (f_q != FW'(NUM_FILTERS - 1)) begin
                    f_d = f_q + FW'(1);
                    acc_d = '0;
                    state_d = S_MAC;
                end else begin
                    f_d = '0;
                    if (ox_q == OXW'(OUT_W - 1)) begin
                        ox_d = '0;
                        if (oy_q == OYW'(OUT_H - 1)) begin
                            oy_d = '0;
                            state_d = S_DONE;
                        end else begin
                            oy_d = oy_q + OYW'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        ox_d = ox_q + OXW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            f_q     <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            f_q     <= f_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            oaddr_q <= oaddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !busy)
            wmem[w_wr_addr] <= w_wr_data;
        if (xfer_in)
            win_q[k_q] <= in_data;
    end

endmodule

// File: tb/tb_conv2d_mc.sv
// Randomized self-checking bench for conv2d_mc against a direct convolution model.
module tb_conv2d_mc;
    localparam int IN_W = 5, IN_H = 5, IN_CH = 2, K = 3, NF = 2, S = 2, DW = 16, FRAC = 8;
    localparam int OUT_W = (IN_W - K) / S + 1;
    localparam int OUT_H = (IN_H - K) / S + 1;
    localparam int N = IN_CH * K * K;
    localparam int WN = NF * N + NF;
    localparam int NIN = IN_W * IN_H * IN_CH;
    localparam int WA_W = $clog2(WN);
    localparam int IA_W = $clog2(NIN);
    localparam int OA_W = $clog2(OUT_W * OUT_H * NF);
    localparam int RUN_CYC = OUT_W * OUT_H * (N + NF * (N + 2)) + 2;

    logic clk = 0, reset = 1, start = 0;
    logic busy, done, in_rd, out_valid;
    logic w_wr_en = 0;
    logic [WA_W-1:0] w_wr_addr = '0;
    logic signed [DW-1:0] w_wr_data = '0;
    logic [IA_W-1:0] in_addr;
    logic signed [DW-1:0] in_data = '0;
    logic in_valid = 0;
    logic out_ready = 1;
    logic [OA_W-1:0] out_addr;
    logic signed [DW-1:0] out_data;

    int inmem [NIN];
    int wts [WN];
    int exp_addr [$];
    int exp_data [$];
    int checks = 0, errors = 0;

    conv2d_mc #(.IN_W(IN_W), .IN_H(IN_H), .IN_CH(IN_CH), .K(K), .NUM_FILTERS(NF),
                .STRIDE(S), .DATA_W(DW), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data));

    always #5 clk = ~clk;

    // Expected results in output order: position (ox fastest, then oy), filters innermost.
    function automatic void build_expected();
        exp_addr.delete();
        exp_data.delete();
        for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++)
                for (int f = 0; f < NF; f++) begin
                    longint acc = 0;
                    longint s;
                    for (int c = 0; c < IN_CH; c++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++)
                                acc += longint'(wts[f*N + c*K*K + ky*K + kx]) *
                                       longint'(inmem[(ox*S + kx) + (oy*S + ky)*IN_W + c*IN_W*IN_H]);
                    s = (acc + longint'(wts[NF*N + f]) * (64'sd1 <<< FRAC)) >>> FRAC;
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
`ifdef CONV2D_MC_RELU_EN
                    if (s < 0) s = 0;
`endif
                    exp_addr.push_back(ox + oy*OUT_W + f*OUT_W*OUT_H);
                    exp_data.push_back(int'(s));
                end
    endfunction

    task automatic write_all();
        for (int i = 0; i < WN; i++) begin
            @(negedge clk);
            w_wr_en = 1;
            w_wr_addr = WA_W'(i);
            w_wr_data = DW'(wts[i]);
        end
        @(negedge clk);
        w_wr_en = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NIN; i++) inmem[i] = int'($urandom_range(2047, 0)) - 1024;
        for (int i = 0; i < WN; i++) wts[i] = int'($urandom_range(1023, 0)) - 512;
    endtask

    task automatic run_conv(input bit rand_in, input int stall, input bit noise,
                            input bit sw_en, input int sw_addr, input int sw_data, output int cyc);
        int st_cnt = 0;
        bit fin = 0;
        bit prev_rd = 0, prev_xfer = 0, prev_ov = 0, prev_rdy = 0;
        logic [IA_W-1:0] prev_ia = '0;
        logic [OA_W-1:0] prev_oa = '0;
        logic signed [DW-1:0] prev_od = '0;
        logic signed [DW-1:0] ed;
        @(negedge clk);
        start = 1;
        w_wr_en = sw_en;
        w_wr_addr = WA_W'(sw_addr);
        w_wr_data = DW'(sw_data);
        cyc = 1;
        while (!fin && cyc < 5000) begin
            if (cyc > 1) begin
                start = 0;
                w_wr_en = noise && busy;
                w_wr_addr = WA_W'($urandom_range(WN - 1, 0));
                w_wr_data = DW'($urandom);
            end
            if (prev_rd && !prev_xfer) begin
                checks++;
                if (in_rd !== 1'b1 || in_addr !== prev_ia) begin
                    errors++;
                    $display("FAIL in_hold: got rd %b addr %0d, expected rd 1 addr %0d", in_rd, in_addr, prev_ia);
                end
            end
            if (in_rd === 1'b1) begin
                in_valid = rand_in ? 1'($urandom_range(1, 0)) : 1'b1;
                in_data = (in_addr < NIN) ? DW'(inmem[in_addr]) : '0;
            end else begin
                in_valid = 0;
            end
            prev_rd = (in_rd === 1'b1);
            prev_xfer = prev_rd && in_valid;
            prev_ia = in_addr;
            if (out_valid === 1'b1) begin
                if (prev_ov && !prev_rdy) begin
                    checks++;
                    if (out_addr !== prev_oa || out_data !== prev_od) begin
                        errors++;
                        $display("FAIL out_hold: got addr %0d data %0d, expected addr %0d data %0d",
                                 out_addr, out_data, prev_oa, prev_od);
                    end
                end
                if (st_cnt < stall) begin
                    out_ready = 0;
                    st_cnt++;
                end else begin
                    out_ready = 1;
                    st_cnt = 0;
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL extra_result: got addr %0d, expected no more results", out_addr);
                    end else begin
                        ed = DW'(exp_data[0]);
                        if (out_addr !== OA_W'(exp_addr[0]) || out_data !== ed) begin
                            errors++;
                            $display("FAIL result: got addr %0d data %0d, expected addr %0d data %0d",
                                     out_addr, out_data, exp_addr[0], ed);
                        end
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(1, 0));
            end
            prev_ov = (out_valid === 1'b1);
            prev_rdy = out_ready;
            prev_oa = out_addr;
            prev_od = out_data;
            if (done === 1'b1) begin
                fin = 1;
                w_wr_en = 0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 0; w_wr_en = 0; in_valid = 0; out_ready = 1;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout: got no done after %0d cycles, expected done", cyc);
        end
        checks++;
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL missing_results: got %0d results short, expected 0", exp_addr.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done %b busy %b after done, expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (in_rd !== 1'b0) begin errors++; $display("FAIL reset_in_rd: got %b expected 0", in_rd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_addr !== '0) begin errors++; $display("FAIL reset_in_addr: got %0d expected 0", in_addr); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        for (int i = 0; i < NIN; i++) inmem[i] = 256;
        for (int i = 0; i < WN; i++) wts[i] = (i < NF*N) ? 256 : 0;
        write_all();
        build_expected();
        run_conv(0, 0, 0, 0, 0, 0, cyc);
        checks++;
        if (cyc != RUN_CYC) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc, RUN_CYC);
        end
    endtask

    task automatic test_multichannel_bias();
        int cyc;
        for (int i = 0; i < NIN; i++) inmem[i] = (i < IN_W*IN_H) ? 256 : 512;
        for (int i = 0; i < WN; i++) wts[i] = (i < NF*N) ? 256 : 0;
        wts[NF*N + 1] = 256;
        write_all();
        build_expected();
        run_conv(0, 0, 0, 0, 0, 0, cyc);
    endtask

    task automatic test_saturation();
        int cyc;
        for (int i = 0; i < WN; i++) wts[i] = (i < NF*N) ? 256 : 0;
        write_all();
        for (int i = 0; i < NIN; i++) inmem[i] = 25600;
        build_expected();
        run_conv(0, 0, 0, 0, 0, 0, cyc);
        for (int i = 0; i < NIN; i++) inmem[i] = -25600;
        build_expected();
        run_conv(0, 0, 0, 0, 0, 0, cyc);
    endtask

    task automatic test_handshake();
        int cyc;
        for (int i = 0; i < NIN; i++) inmem[i] = 256;
        for (int i = 0; i < WN; i++) wts[i] = (i < NF*N) ? 256 : 0;
        write_all();
        build_expected();
        run_conv(1, 3, 0, 0, 0, 0, cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int r = 0; r < 3; r++) begin
            rand_data();
            write_all();
            build_expected();
            run_conv(1, 3, 1, 0, 0, 0, cyc);
        end
    endtask

    task automatic test_start_with_write();
        int cyc, addr, val;
        rand_data();
        write_all();
        addr = NF*N + 1;
        val = int'($urandom_range(4095, 0)) - 2048;
        wts[addr] = val;
        build_expected();
        run_conv(1, 1, 0, 1, addr, val, cyc);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        rand_data();
        write_all();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < N + 3; i++) begin
            in_valid = (in_rd === 1'b1);
            in_data = (in_addr < NIN) ? DW'(inmem[in_addr]) : '0;
            @(negedge clk);
        end
        reset = 1;
        in_valid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_rd !== 1'b0) begin errors++; $display("FAIL abort_in_rd: got %b expected 0", in_rd); end
        checks++; if (out_addr !== '0 || out_data !== '0) begin
            errors++; $display("FAIL abort_outputs: got addr %0d data %0d expected 0 0", out_addr, out_data);
        end
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        build_expected();
        run_conv(1, 2, 1, 0, 0, 0, cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multichannel_bias();
        test_saturation();
        test_handshake();
        test_random();
        test_start_with_write();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv2d_mc.md
# conv2d_mc

Multi-channel, strided 2-D convolution engine with loadable weights and per-filter bias. It reads an input feature map from an external memory through a request/valid port and computes every filter at every output position. Results go to an output memory through a valid/ready port with backpressure. It replaces the random-weight single-channel convolution stage in the CNN pipeline and feeds the pooling stage.

## Interface
Parameters:
- IN_W, 28, input width in pixels
- IN_H, 28, input height in pixels
- IN_CH, 1, input channels
- K, 3, square kernel size
- NUM_FILTERS, 8, output channels
- STRIDE, 1, horizontal and vertical stride
- DATA_W, 16, signed fixed-point sample/weight width
- FRAC, 8, fractional bits of every DATA_W value

Derived values:
- OUT_W = (IN_W-K)/STRIDE+1
- OUT_H = (IN_H-K)/STRIDE+1
- N = IN_CH*K*K
- WN = NUM_FILTERS*N+NUM_FILTERS (weight plus bias words)

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin one full convolution; sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at completion
- w_wr_en  in  1  weight/bias write strobe; ignored while busy
- w_wr_addr  in  clog2(WN)  weight index f*N + c*K*K + ky*K + kx; bias of filter f at NUM_FILTERS*N + f
- w_wr_data  in  DATA_W  signed weight or bias
- in_rd  out  1  input read request
- in_addr  out  clog2(IN_W*IN_H*IN_CH)  x + y*IN_W + c*IN_W*IN_H
- in_data  in  DATA_W  input sample
- in_valid  in  1  in_data valid; transfer occurs when in_rd && in_valid
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts; transfer occurs when out_valid && out_ready
- out_addr  out  clog2(OUT_W*OUT_H*NUM_FILTERS)  ox + oy*OUT_W + f*OUT_W*OUT_H
- out_data  out  DATA_W  result

## Operation
- States:
  - IDLE: start → FETCH; counters cleared.
  - FETCH: loads N samples of the current window into a buffer, in order c, ky, kx (kx fastest); after N transfers → MAC with f=0.
  - MAC: one multiply-accumulate per cycle over N terms → FINAL.
  - FINAL: bias add, shift, saturate, optional clamp → WRITE.
  - WRITE: holds out_valid until the transfer occurs, then one of:
    - f<NUM_FILTERS-1: f+1 → MAC, reusing the window buffer;
    - f is the last filter: next position (ox fastest, then oy) → FETCH;
    - last position: → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Window origin: (ox*STRIDE, oy*STRIDE).
- Arithmetic:
  - Products are full 2*DATA_W bits.
  - Accumulator ACC_W = 2*DATA_W + clog2(N) + 1 bits, sign-extended; no intermediate truncation.
  - FINAL computes s = (acc + (bias <<< FRAC)) >>> FRAC (arithmetic shift), then saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Weight memory:
  - Written only by w_wr_en while not busy.
  - Not cleared by reset; contents are retained across reset.
  - Undefined at power-up.
- start while busy is ignored. start and w_wr_en in the same IDLE cycle: the write completes and the run uses the new value.

## Timing
- Reset values:
  - busy=0, done=0, in_rd=0, out_valid=0.
  - in_addr=0, out_addr=0, out_data=0.
  - State IDLE, all counters 0.
- in_rd and in_addr hold stable until the transfer completes. The next address follows the cycle after the transfer. There is at most one outstanding request.
- out_valid, out_addr and out_data hold stable while out_ready=0.
- Latency with in_valid and out_ready tied high:
  - FETCH is N cycles per position.
  - Each filter costs N (MAC) + 1 (FINAL) + 1 (WRITE) cycles.
  - Total = OUT_W*OUT_H*(N + NUM_FILTERS*(N+2)) + 2 cycles from start to done.
- Reset mid-run aborts immediately: all outputs go to their reset values and no further writes are issued.

## Configuration
- CONV2D_MC_RELU_EN
  - Defined: FINAL clamps negative saturated results to 0 (fused ReLU).
  - Undefined: signed results pass through unchanged.

## Test plan
- Basic sum: IN_W=IN_H=4, IN_CH=1, K=3, NUM_FILTERS=1; all weights 256, bias 0, all inputs 256 → four outputs of 2304 at out_addr 0..3, then one done pulse.
- Saturation: as the basic sum but inputs 25600 (100.0) → all outputs 32767. Inputs -25600 → -32768 without the macro, 0 with CONV2D_MC_RELU_EN.
- Multi-channel, stride and bias: IN_CH=2, STRIDE=2, 5x5 input, channel 0 = 256 and channel 1 = 512, weights 256, filter-1 bias 256 → 2x2 outputs per filter. Filter 0 gives 6912; filter 1 gives 7168 at out_addr 4..7.
- Handshakes:
  - in_valid pseudo-random 50% and out_ready low 3 cycles per result → identical out_addr/out_data sequence to the basic case.
  - in_addr and out_data are stable during stalls.
- Reset and protocol: reset asserted mid-MAC → next cycle busy=0, out_valid=0, in_rd=0. A new start gives a full correct run using the retained weights. w_wr_en during busy has no effect on results.
